// File: rtl/mem_sram_ctrl.sv
// ---------------------------------------------------------------------------------------------
// mem_sram_ctrl
//
// MEM-stage data-memory responder. Serves 32-bit load/store requests from the MEM stage by
// moving each word to/from an external 16-bit asynchronous SRAM as two half-word accesses
// (low half first). Ready is held low while an access is in flight so the freeze logic stalls
// the pipeline; it is high for one cycle in DONE, and high in IDLE when nothing is requested.
//
// Sequence: IDLE -> ACC_LO -> ACC_HI -> PAD (WAIT_CYCLES cycles, skipped if 0) -> DONE -> IDLE
//
// Parameters
//   BASE_ADDR    byte address mapped to SRAM word 0
//   WAIT_CYCLES  pad cycles after the high half-word access (0..15)
//   SRAM_AW      SRAM half-word address width
//
// Ports
//   CLK          clock, all state on the rising edge
//   RST          asynchronous reset, active-high
//   WR_EN        store request, held until Ready=1 (wins over RD_EN)
//   RD_EN        load request, held until Ready=1
//   Address      byte address of the request
//   Write_Data   store data
//   Read_Data    registered load data, updated at the end of ACC_HI of a read
//   Ready        0 = freeze pipeline (combinational from state and requests)
//   SRAM_ADDR    half-word address, {word, 0} for the low half, {word, 1} for the high half
//   SRAM_WE_N    active-low write strobe
//   SRAM_DQ_OUT  half-word driven during writes
//   SRAM_DQ_OE   1 = drive SRAM_DQ_OUT onto the bus
//   SRAM_DQ_IN   half-word read from the bus
//
// Configuration macro
//   SRAM_FAST_WRITE_EN  when defined, writes go ACC_HI -> DONE and skip PAD; reads unchanged.
// ---------------------------------------------------------------------------------------------
module mem_sram_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               WR_EN,
    input  logic               RD_EN,
    input  logic [31:0]        Address,
    input  logic [31:0]        Write_Data,
    output logic [31:0]        Read_Data,
    output logic               Ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic [15:0]        SRAM_DQ_OUT,
    output logic               SRAM_DQ_OE,
    input  logic [15:0]        SRAM_DQ_IN
);

    localparam int unsigned WordW   = SRAM_AW - 1;
    localparam bit          HasPad  = (WAIT_CYCLES != 0);
    // Only used when HasPad; value for WAIT_CYCLES=0 is irrelevant.
    localparam logic [3:0]  PadLast = 4'(WAIT_CYCLES - 1);

`ifdef SRAM_FAST_WRITE_EN
    localparam bit FastWrite = 1'b1;
`else
    localparam bit FastWrite = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StAccLo,
        StAccHi,
        StPad,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic               is_wr_q, is_wr_d;
    logic [WordW-1:0]   word_q, word_d;
    logic [15:0]        wdata_hi_q, wdata_hi_d;
    logic [15:0]        rd_lo_q, rd_lo_d;
    logic [31:0]        read_data_q, read_data_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic               we_n_q, we_n_d;
    logic               oe_q, oe_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic [3:0]         cnt_q, cnt_d;

    logic [31:0]        offset;
    logic [WordW-1:0]   req_word;
    logic               req_any;
    logic               skip_pad;
    logic               unused_offset_bits;

    // Word index wraps modulo 2^WordW: only the bits that fit the SRAM are kept.
    assign offset             = Address - BASE_ADDR;
    assign req_word           = offset[WordW+1:2];
    assign unused_offset_bits = ^{offset[31:WordW+2], offset[1:0]};
    assign req_any            = WR_EN | RD_EN;
    assign skip_pad           = !HasPad || (FastWrite && is_wr_q);

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        word_d      = word_q;
        wdata_hi_d  = wdata_hi_q;
        rd_lo_d     = rd_lo_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        we_n_d      = we_n_q;
        oe_d        = oe_q;
        dq_out_d    = dq_out_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    // Op and word are latched here; the access runs to completion even if
                    // the request is dropped later.
                    state_d     = StAccLo;
                    is_wr_d     = WR_EN;
                    word_d      = req_word;
                    wdata_hi_d  = Write_Data[31:16];
                    sram_addr_d = {req_word, 1'b0};
                    if (WR_EN) begin
                        // Strobe outputs are registered, so they are set up on entry.
                        we_n_d   = 1'b0;
                        oe_d     = 1'b1;
                        dq_out_d = Write_Data[15:0];
                    end
                end
            end

            StAccLo: begin
                state_d     = StAccHi;
                sram_addr_d = {word_q, 1'b1};
                if (is_wr_q) begin
                    dq_out_d = wdata_hi_q;
                end else begin
                    rd_lo_d = SRAM_DQ_IN;
                end
            end

            StAccHi: begin
                we_n_d = 1'b1;
                oe_d   = 1'b0;
                if (!is_wr_q) begin
                    read_data_d = {SRAM_DQ_IN, rd_lo_q};
                end
                if (skip_pad) begin
                    state_d = StDone;
                end else begin
                    state_d = StPad;
                    cnt_d   = 4'd0;
                end
            end

            StPad: begin
                if (cnt_q == PadLast) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            is_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_hi_q  <= 16'h0;
            rd_lo_q     <= 16'h0;
            read_data_q <= 32'h0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            oe_q        <= 1'b0;
            dq_out_q    <= 16'h0;
            cnt_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            word_q      <= word_d;
            wdata_hi_q  <= wdata_hi_d;
            rd_lo_q     <= rd_lo_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            we_n_q      <= we_n_d;
            oe_q        <= oe_d;
            dq_out_q    <= dq_out_d;
            cnt_q       <= cnt_d;
        end
    end

    assign Ready       = (state_q == StDone) || ((state_q == StIdle) && !req_any);
    assign Read_Data   = read_data_q;
    assign SRAM_ADDR   = sram_addr_q;
    assign SRAM_WE_N   = we_n_q;
    assign SRAM_DQ_OE  = oe_q;
    assign SRAM_DQ_OUT = dq_out_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
module tb_mem_sram_ctrl;

    localparam int unsigned WC   = 2;
    localparam int unsigned AW   = 18;
    localparam logic [31:0] BASE = 32'd1024;

    logic          CLK;
    logic          RST;
    logic          WR_EN;
    logic          RD_EN;
    logic [31:0]   Address;
    logic [31:0]   Write_Data;
    logic [31:0]   Read_Data;
    logic          Ready;
    logic [AW-1:0] SRAM_ADDR;
    logic          SRAM_WE_N;
    logic [15:0]   SRAM_DQ_OUT;
    logic          SRAM_DQ_OE;
    logic [15:0]   SRAM_DQ_IN;

    mem_sram_ctrl #(
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(WC),
        .SRAM_AW    (AW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .WR_EN      (WR_EN),
        .RD_EN      (RD_EN),
        .Address    (Address),
        .Write_Data (Write_Data),
        .Read_Data  (Read_Data),
        .Ready      (Ready),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_DQ_OUT(SRAM_DQ_OUT),
        .SRAM_DQ_OE (SRAM_DQ_OE),
        .SRAM_DQ_IN (SRAM_DQ_IN)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Asynchronous SRAM: combinational read, write captured mid-cycle while strobed.
    logic [15:0] sram [0:(1<<AW)-1];
    assign SRAM_DQ_IN = sram[SRAM_ADDR];
    initial begin
        for (int i = 0; i < (1 << AW); i++) sram[i] = 16'h0;
        forever begin
            @(negedge CLK);
            if (!SRAM_WE_N && SRAM_DQ_OE) sram[SRAM_ADDR] = SRAM_DQ_OUT;
        end
    end

    // Word-level reference: contents per word index plus expected load result.
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] exp_rd;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          rdy_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] word_of(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - BASE) >> 2;
        return off[16:0];
    endfunction

    function automatic logic [31:0] ref_read(input logic [16:0] w);
        if (ref_mem.exists(int'(w))) return ref_mem[int'(w)];
        return 32'h0;
    endfunction

    // Called at #1 after a rising edge with the DUT idle. Leaves at #1 after the DONE edge.
    task automatic do_access(input logic wr, input logic rd, input logic [31:0] addr,
                             input logic [31:0] data, input bit hold);
        logic [16:0] w;
        logic        is_wr;
        int          n;
        int          exp_lat;
        w     = word_of(addr);
        is_wr = wr;
        exp_lat = 3 + int'(WC);
`ifdef SRAM_FAST_WRITE_EN
        if (is_wr) exp_lat = 3;
`endif
        WR_EN = wr; RD_EN = rd; Address = addr; Write_Data = data;
        @(negedge CLK);
        check("ready_in_req_idle", {31'b0, Ready}, 32'd0);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            if (n == 1) begin
                check("lo_addr", {14'b0, SRAM_ADDR}, {14'b0, w, 1'b0});
                check("lo_we_n", {31'b0, SRAM_WE_N}, {31'b0, ~is_wr});
                check("lo_oe", {31'b0, SRAM_DQ_OE}, {31'b0, is_wr});
                if (is_wr) check("lo_dq", {16'b0, SRAM_DQ_OUT}, {16'b0, data[15:0]});
            end
            if (n == 2) begin
                check("hi_addr", {14'b0, SRAM_ADDR}, {14'b0, w, 1'b1});
                check("hi_we_n", {31'b0, SRAM_WE_N}, {31'b0, ~is_wr});
                if (is_wr) check("hi_dq", {16'b0, SRAM_DQ_OUT}, {16'b0, data[31:16]});
            end
            if (n == 3) begin
                check("post_we_n", {31'b0, SRAM_WE_N}, 32'd1);
                check("post_oe", {31'b0, SRAM_DQ_OE}, 32'd0);
            end
        end while (!Ready && n < 40);
        rdy_cyc = cyc;
        check("latency", n, exp_lat);
        if (is_wr) ref_mem[int'(w)] = data;
        else exp_rd = ref_read(w);
        check("read_data", Read_Data, exp_rd);
        @(posedge CLK);
        #1;
        if (!hold) begin
            WR_EN = 1'b0;
            RD_EN = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        logic [31:0] old;
        int          t1;
        int          op;

        RST = 1'b1; WR_EN = 1'b0; RD_EN = 1'b0; Address = 32'h0; Write_Data = 32'h0;
        exp_rd = 32'h0;
        #12;
        check("rst_read_data", Read_Data, 32'h0);
        check("rst_we_n", {31'b0, SRAM_WE_N}, 32'd1);
        check("rst_oe", {31'b0, SRAM_DQ_OE}, 32'd0);
        check("rst_addr", {14'b0, SRAM_ADDR}, 32'h0);
        check("rst_ready", {31'b0, Ready}, 32'd1);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Idle, no request.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("idle_ready", {31'b0, Ready}, 32'd1);
            check("idle_we_n", {31'b0, SRAM_WE_N}, 32'd1);
            check("idle_oe", {31'b0, SRAM_DQ_OE}, 32'd0);
        end
        @(posedge CLK);
        #1;

        // Directed write/read, then both-enables (write wins).
        do_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0);
        do_access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        check("read_hold", Read_Data, 32'hDEADBEEF);
        do_access(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0);
        check("sram_w0_lo", {16'b0, sram[0]}, 32'h5678);
        check("sram_w0_hi", {16'b0, sram[1]}, 32'h1234);

        // Back-to-back read with the request kept asserted through DONE.
        do_access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b1);
        t1 = rdy_cyc;
        do_access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);
        check("b2b_gap", rdy_cyc - t1, 32'd6);

        // Reset asserted in the middle of ACC_HI of a write.
        d = $urandom;
        a = 32'd1040;
        old = ref_read(word_of(a));
        WR_EN = 1'b1; Address = a; Write_Data = d;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("arst_we_n", {31'b0, SRAM_WE_N}, 32'd1);
        check("arst_oe", {31'b0, SRAM_DQ_OE}, 32'd0);
        check("arst_read_data", Read_Data, 32'h0);
        check("arst_addr", {14'b0, SRAM_ADDR}, 32'h0);
        check("arst_dq", {16'b0, SRAM_DQ_OUT}, 32'h0);
        check("arst_ready_req", {31'b0, Ready}, 32'd0);
        WR_EN = 1'b0;
        #1;
        check("arst_ready_idle", {31'b0, Ready}, 32'd1);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        // Only the low half reached the SRAM before reset.
        ref_mem[int'(word_of(a))] = {old[31:16], d[15:0]};
        exp_rd = 32'h0;
        do_access(1'b0, 1'b1, a, 32'h0, 1'b0);

        // Randomized traffic including wrapping addresses.
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 2));
            case ($urandom_range(0, 7))
                0:       a = BASE - 32'(4 * $urandom_range(1, 3));
                1:       a = BASE + 32'h0008_0000 + 32'(4 * $urandom_range(0, 15));
                default: a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            endcase
            d = $urandom;
            do_access(op != 1, op != 0, a, d, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK);
                #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
